prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//   Writer side of the instruction-fetch path: receives a program as a byte stream, packs bytes into
//   9-bit instructions and writes them into the instruction RAM that the processor PC fetches from.
//   Holds the processor in init (cpu_start high) while loading, releases it, then waits for halt.
//   Sits between the host/bench byte source and TopLevel (drives its start, observes its halt).
// PARAMETERS
//   A_W           10  instruction address width (program holds up to 2**A_W instructions)
//   I_W           9   instruction width; fixed at 9 (bit 8 carried in second byte bit 0)
//   START_CYCLES  2   cycles cpu_start is held high after the last write, so the PC initializes
// PORTS
//   CLK           in   1      clock, posedge
//   reset         in   1      asynchronous, active-high reset
//   load_req      in   1      begin a new load (honoured in IDLE, DONE, ERR)
//   rx_data       in   8      program byte
//   rx_valid      in   1      rx_data valid
//   rx_ready      out  1      loader accepts byte; transfer when rx_valid && rx_ready
//   inst_wr_en    out  1      instruction RAM write strobe, one cycle per instruction
//   inst_wr_addr  out  A_W    instruction RAM write address
//   inst_wr_data  out  I_W    instruction RAM write data
//   cpu_start     out  1      processor init/reset (TopLevel start), active high
//   cpu_halt      in   1      processor done flag (TopLevel halt)
//   busy          out  1      load or run in progress (any state except IDLE, DONE, ERR)
//   done          out  1      processor halted after a successful load
//   error         out  1      malformed stream; sticky until reset or load_req
//   inst_count    out  A_W+1  instruction count from the header
// BEHAVIOUR
//   Reset (async, immediate): state IDLE; rx_ready, inst_wr_en, busy, done, error = 0; inst_wr_addr,
//     inst_wr_data, inst_count, write pointer, start counter = 0; cpu_start = 1.
//   Stream: 2 header bytes (count low, count high), then 2 bytes per instruction (bits 7:0, then
//     bit 8 in byte bit 0). Byte order is fixed; no padding or trailer.
//   rx_ready decoded from state only, never from rx_valid: 1 in HDR_LO, HDR_HI, INST_LO, INST_HI.
//   States/transitions (all on accepted byte unless noted):
//     IDLE    : load_req -> HDR_LO; clears error, done, write pointer.
//     HDR_LO  : count[7:0] = byte -> HDR_HI.
//     HDR_HI  : count[A_W:8] = byte; count==0 or count>2**A_W or byte bits above A_W-8 nonzero
//               -> ERR; else -> INST_LO. inst_count updates on this accept.
//     INST_LO : latch low byte -> INST_HI.
//     INST_HI : byte[7:1]!=0 -> ERR, no write. Else registered write: next cycle inst_wr_en=1,
//               inst_wr_addr=wptr, inst_wr_data={byte[0],low}; wptr+1; wptr+1==count -> START,
//               else -> INST_LO. wptr never wraps (count bounded by 2**A_W).
//     START   : cpu_start=1 for START_CYCLES cycles counted from the cycle after the last write
//               strobe -> RUN.
//     RUN     : cpu_start=0; cpu_halt ignored in first RUN cycle, sampled from the second;
//               cpu_halt -> DONE. load_req ignored (halt wins if simultaneous).
//     DONE    : done=1, cpu_start=0 (halt stays visible); load_req -> HDR_LO, done cleared.
//     ERR     : error=1, cpu_start=1; load_req -> HDR_LO, error cleared.
//   cpu_start = 1 in every state except RUN and DONE.
//   load_req outside IDLE/DONE/ERR has no effect. rx_valid with rx_ready=0 is never consumed.
//   Gaps in rx_valid stall the FSM in place; no duplicate or dropped writes.
//   Reset mid-load: in-flight instruction discarded, inst_wr_en drops at once, memory contents
//     already written are not cleared.
// TESTING
//   T1 load_req; bytes 03 00 | 12 01 | 34 00 | FF 01 -> writes 0:0x112, 1:0x034, 2:0x1FF;
//      cpu_start high 2 cycles after last strobe, then low; rx_ready low from START on.
//   T2 same stream, rx_valid toggled randomly with 0-5 idle cycles -> identical 3 writes, no extras.
//   T3 header 00 00 -> error=1, zero writes, cpu_start=1; header 01 04 (0x401) -> error=1;
//      header 00 04 -> 1024 writes, last inst_wr_addr=0x3FF, no error.
//   T4 instruction high byte 0x03 -> error=1, that instruction not written; load_req clears error.
//   T5 cpu_halt at RUN cycle 1 ignored; asserted at RUN cycle 10 -> done=1, busy=0 next cycle;
//      load_req in DONE -> HDR_LO, done=0, cpu_start=1.
//   T6 reset mid INST_HI -> same cycle: inst_wr_en=0, rx_ready=0, cpu_start=1; state IDLE after release.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: receives a program as a byte stream, packs byte pairs into
// 9-bit instructions, writes them into the instruction RAM, and then
// sequences the processor through init (cpu_start), run and halt.
// The header carries the instruction count in little-endian byte order.
// A_W is assumed to lie between 8 and 15 so the count high byte carries
// bits A_W:8.
module prog_loader #(
    parameter int A_W          = 10,
    parameter int I_W          = 9,
    parameter int START_CYCLES = 2
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic           load_req,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    output logic           rx_ready,
    output logic           inst_wr_en,
    output logic [A_W-1:0] inst_wr_addr,
    output logic [I_W-1:0] inst_wr_data,
    output logic           cpu_start,
    input  logic           cpu_halt,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [A_W:0]   inst_count
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] HDR_LO  = 4'd1;
    localparam logic [3:0] HDR_HI  = 4'd2;
    localparam logic [3:0] INST_LO = 4'd3;
    localparam logic [3:0] INST_HI = 4'd4;
    localparam logic [3:0] START   = 4'd5;
    localparam logic [3:0] RUN     = 4'd6;
    localparam logic [3:0] DONE    = 4'd7;
    localparam logic [3:0] ERR     = 4'd8;

    // Start counter is wide enough to reach START_CYCLES; in RUN it is
    // reused as a "first cycle already seen" flag.
    localparam int SC_W = (START_CYCLES < 1) ? 1 : $clog2(START_CYCLES + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(START_CYCLES);
    localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);
    localparam logic [A_W:0]    PTR_ONE = (A_W+1)'(1);
    localparam logic [A_W:0]    MAX_COUNT = PTR_ONE << A_W;

    logic [3:0]      state_q, state_d;
    logic [7:0]      cnt_lo_q, cnt_lo_d;
    logic [A_W:0]    count_q, count_d;
    logic [7:0]      lo_byte_q, lo_byte_d;
    logic [A_W:0]    wptr_q, wptr_d;
    logic [SC_W-1:0] start_cnt_q, start_cnt_d;
    logic            wr_en_q, wr_en_d;
    logic [A_W-1:0]  wr_addr_q, wr_addr_d;
    logic [I_W-1:0]  wr_data_q, wr_data_d;

    logic            byte_acc;
    logic [A_W:0]    hdr_count;
    logic [7:0]      hdr_extra;
    logic [A_W:0]    wptr_inc;
    logic            hdr_bad;

    // rx_ready depends on state only, so a waiting byte never influences it.
    assign rx_ready = (state_q == HDR_LO) || (state_q == HDR_HI) ||
                      (state_q == INST_LO) || (state_q == INST_HI);
    assign byte_acc = rx_valid && rx_ready;

    // Status decode: the processor is held in init everywhere except while
    // it runs or sits halted after a good load.
    assign cpu_start = !((state_q == RUN) || (state_q == DONE));
    assign busy      = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERR);

    assign inst_wr_en   = wr_en_q;
    assign inst_wr_addr = wr_addr_q;
    assign inst_wr_data = wr_data_q;
    assign inst_count   = count_q;

    // Header decode: count high bits come from the low bits of the byte;
    // any bit above them makes the header malformed.
    assign hdr_count = {rx_data[A_W-8:0], cnt_lo_q};
    assign hdr_extra = rx_data >> (A_W - 7);
    assign hdr_bad   = (hdr_extra != 8'd0) || (hdr_count == '0) || (hdr_count > MAX_COUNT);
    assign wptr_inc  = wptr_q + PTR_ONE;

    // Next-state and datapath decode for the loader/run sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_lo_d    = cnt_lo_q;
        count_d     = count_q;
        lo_byte_d   = lo_byte_q;
        wptr_d      = wptr_q;
        start_cnt_d = start_cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (load_req) begin
                    state_d     = HDR_LO;
                    wptr_d      = '0;
                    start_cnt_d = '0;
                end
            end
            HDR_LO: begin
                if (byte_acc) begin
                    cnt_lo_d = rx_data;
                    state_d  = HDR_HI;
                end
            end
            HDR_HI: begin
                if (byte_acc) begin
                    count_d = hdr_count;
                    state_d = hdr_bad ? ERR : INST_LO;
                end
            end
            INST_LO: begin
                if (byte_acc) begin
                    lo_byte_d = rx_data;
                    state_d   = INST_HI;
                end
            end
            INST_HI: begin
                if (byte_acc) begin
                    if (rx_data[7:1] != 7'd0) begin
                        // Malformed high byte: drop the instruction entirely.
                        state_d = ERR;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = wptr_q[A_W-1:0];
                        wr_data_d = {rx_data[0], lo_byte_q};
                        wptr_d    = wptr_inc;
                        if (wptr_inc == count_q) begin
                            state_d     = START;
                            start_cnt_d = '0;
                        end else begin
                            state_d = INST_LO;
                        end
                    end
                end
            end
            START: begin
                // First START cycle carries the last write strobe; the
                // following START_CYCLES cycles keep the PC in init.
                if (start_cnt_q == SC_LAST) begin
                    state_d     = RUN;
                    start_cnt_d = '0;
                end else begin
                    start_cnt_d = start_cnt_q + SC_ONE;
                end
            end
            RUN: begin
                // Halt may still be stale from a previous run in the first
                // cycle, so it is only honoured from the second cycle on.
                if (start_cnt_q == '0) begin
                    start_cnt_d = SC_ONE;
                end else if (cpu_halt) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset is immediate and leaves the CPU held.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_lo_q    <= '0;
            count_q     <= '0;
            lo_byte_q   <= '0;
            wptr_q      <= '0;
            start_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_lo_q    <= cnt_lo_d;
            count_q     <= count_d;
            lo_byte_q   <= lo_byte_d;
            wptr_q      <= wptr_d;
            start_cnt_q <= start_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a reference model parses each byte stream and
// queues the expected RAM writes; a monitor pops and compares every strobe.
module tb_prog_loader;

    logic        CLK;
    logic        reset;
    logic        load_req;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        inst_wr_en;
    logic [9:0]  inst_wr_addr;
    logic [8:0]  inst_wr_data;
    logic        cpu_start;
    logic        cpu_halt;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] inst_count;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;
    int  last_addr = -1;
    int  load_no = 0;

    prog_loader dut (
        .CLK          (CLK),
        .reset        (reset),
        .load_req     (load_req),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .inst_wr_en   (inst_wr_en),
        .inst_wr_addr (inst_wr_addr),
        .inst_wr_data (inst_wr_data),
        .cpu_start    (cpu_start),
        .cpu_halt     (cpu_halt),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .inst_count   (inst_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge CLK) begin
        if (!reset && inst_wr_en) begin
            last_addr = int'(inst_wr_addr);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h required no write",
                         inst_wr_addr, inst_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(inst_wr_addr), mon_e.addr);
                check("wr_data", 32'(inst_wr_data), mon_e.data);
            end
        end
    end

    // Reference model: parse the stream by its rules, queue the writes it
    // implies, and report how many bytes the loader will consume.
    function automatic void model(input logic [7:0] s[$], output int consumed,
                                  output bit err, output int cnt);
        wr_t w;
        int lo, hi;
        consumed = 2;
        err = 1'b0;
        cnt = int'(s[1]) * 256 + int'(s[0]);
        if (cnt == 0 || cnt > 1024) begin
            err = 1'b1;
            return;
        end
        for (int i = 0; i < cnt; i++) begin
            lo = int'(s[2 + 2*i]);
            hi = int'(s[3 + 2*i]);
            consumed += 2;
            if (hi > 1) begin
                err = 1'b1;
                return;
            end
            w.addr = i;
            w.data = hi * 256 + lo;
            exp_q.push_back(w);
        end
    endfunction

    function automatic void make_stream(output logic [7:0] s[$], input int n, input bit allow_bad);
        int v;
        s = {};
        v = n;
        if (allow_bad && $urandom_range(5, 0) == 0) begin
            case ($urandom_range(2, 0))
                0: s = '{8'h00, 8'h00};
                1: s = '{8'h01, 8'h04};
                default: s = '{8'($urandom), 8'($urandom_range(255, 8))};
            endcase
        end else begin
            s.push_back(v[7:0]);
            s.push_back(v[15:8]);
        end
        for (int i = 0; i < n; i++) begin
            s.push_back(8'($urandom));
            if (allow_bad && $urandom_range(15, 0) == 0)
                s.push_back(8'($urandom_range(255, 2)));
            else
                s.push_back(8'($urandom_range(1, 0)));
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int waited;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            load_req = ($urandom_range(3, 0) == 0);
            @(negedge CLK);
        end
        load_req = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        waited   = 0;
        while (!rx_ready && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout: got rx_ready 0 required 1");
        end
        @(negedge CLK);
        rx_valid = 1'b0;
    endtask

    task automatic do_load();
        load_req = 1'b1;
        @(negedge CLK);
        load_req = 1'b0;
        check("load_busy", 32'(busy), 1);
        check("load_rx_ready", 32'(rx_ready), 1);
        check("load_error_clr", 32'(error), 0);
        check("load_done_clr", 32'(done), 0);
        check("load_cpu_start", 32'(cpu_start), 1);
    endtask

    // Entered at the first RUN cycle.
    task automatic run_phase(input int halt_at);
        cpu_halt = 1'b1;
        @(negedge CLK);
        cpu_halt = 1'b0;
        check("halt_first_ignored", 32'(done), 0);
        check("run_busy", 32'(busy), 1);
        @(negedge CLK);
        load_req = 1'b1;
        @(negedge CLK);
        load_req = 1'b0;
        check("load_in_run_rx_ready", 32'(rx_ready), 0);
        check("load_in_run_cpu_start", 32'(cpu_start), 0);
        repeat (halt_at - 4) @(negedge CLK);
        cpu_halt = 1'b1;
        load_req = 1'b1;
        @(negedge CLK);
        cpu_halt = 1'b0;
        load_req = 1'b0;
        check("halt_done", 32'(done), 1);
        check("halt_busy", 32'(busy), 0);
        check("halt_cpu_start", 32'(cpu_start), 0);
        @(negedge CLK);
        check("done_sticky", 32'(done), 1);
    endtask

    task automatic run_stream(input logic [7:0] s[$], input int max_gap, input int halt_at);
        int consumed, cnt, nhi;
        bit err;
        model(s, consumed, err, cnt);
        load_no++;
        $display("load %0d: count=%0d bytes=%0d writes=%0d expect_error=%0d",
                 load_no, cnt, consumed, exp_q.size(), err);
        for (int i = 0; i < consumed; i++) send_byte(s[i], max_gap);
        // The count register holds only the low A_W+1 header bits.
        check("inst_count", 32'(inst_count), (int'(s[1]) % 8) * 256 + int'(s[0]));
        if (err) begin
            check("err_flag", 32'(error), 1);
            check("err_cpu_start", 32'(cpu_start), 1);
            check("err_busy", 32'(busy), 0);
            check("err_rx_ready", 32'(rx_ready), 0);
            @(negedge CLK);
            check("err_writes_left", 32'(exp_q.size()), 0);
        end else begin
            check("last_strobe", 32'(inst_wr_en), 1);
            check("start_rx_ready", 32'(rx_ready), 0);
            check("start_cpu_start", 32'(cpu_start), 1);
            nhi = 0;
            while (nhi < 20) begin
                @(negedge CLK);
                if (!cpu_start) break;
                nhi++;
            end
            check("start_hold_cycles", 32'(nhi), 2);
            check("writes_left", 32'(exp_q.size()), 0);
            run_phase(halt_at);
        end
    endtask

    initial begin
        logic [7:0] s[$];
        wr_t w;

        reset    = 1'b1;
        load_req = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        cpu_halt = 1'b0;
        #1;
        check("rst_cpu_start", 32'(cpu_start), 1);
        check("rst_rx_ready", 32'(rx_ready), 0);
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        check("idle_wr_en", 32'(inst_wr_en), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);
        check("idle_error", 32'(error), 0);
        check("idle_cpu_start", 32'(cpu_start), 1);
        check("idle_inst_count", 32'(inst_count), 0);
        check("idle_wr_addr", 32'(inst_wr_addr), 0);
        check("idle_wr_data", 32'(inst_wr_data), 0);
        check("idle_rx_ready", 32'(rx_ready), 0);

        // T1 / T5: directed stream, halt ignored in RUN cycle 1, halt at cycle 10.
        do_load();
        s = '{8'h03, 8'h00, 8'h12, 8'h01, 8'h34, 8'h00, 8'hFF, 8'h01};
        run_stream(s, 0, 10);

        // T2: same stream with random idle gaps.
        do_load();
        run_stream(s, 5, 7);

        // T3: malformed headers, then a full 1024-instruction program.
        do_load();
        s = '{8'h00, 8'h00};
        run_stream(s, 0, 6);
        do_load();
        s = '{8'h01, 8'h04, 8'h00, 8'h00};
        run_stream(s, 1, 6);
        do_load();
        make_stream(s, 1024, 1'b0);
        run_stream(s, 0, 5);
        check("last_wr_addr", 32'(last_addr), 32'h3FF);

        // T4: bad high byte on the second instruction.
        do_load();
        s = '{8'h02, 8'h00, 8'h55, 8'h00, 8'h66, 8'h03};
        run_stream(s, 0, 5);

        // Randomized programs, some malformed.
        for (int it = 0; it < 14; it++) begin
            do_load();
            make_stream(s, int'($urandom_range(20, 1)), 1'b1);
            run_stream(s, 3, int'($urandom_range(12, 4)));
        end

        // T6a: reset while a write strobe is on the bus.
        do_load();
        w.addr = 0;
        w.data = 'h15A;
        exp_q.push_back(w);
        s = '{8'h03, 8'h00, 8'h5A, 8'h01};
        for (int i = 0; i < 4; i++) send_byte(s[i], 0);
        check("pre_rst_strobe", 32'(inst_wr_en), 1);
        #1 reset = 1'b1;
        #1;
        check("rst_wr_en_drop", 32'(inst_wr_en), 0);
        check("rst_busy_drop", 32'(busy), 0);
        check("rst_mid_cpu_start", 32'(cpu_start), 1);
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_count", 32'(inst_count), 0);

        // T6b: reset in INST_HI with a byte offered.
        do_load();
        w.addr = 0;
        w.data = 'h011;
        exp_q.push_back(w);
        s = '{8'h02, 8'h00, 8'h11, 8'h00, 8'h22};
        for (int i = 0; i < 5; i++) send_byte(s[i], 0);
        check("inst_hi_rx_ready", 32'(rx_ready), 1);
        rx_valid = 1'b1;
        rx_data  = 8'h01;
        #1 reset = 1'b1;
        #1;
        check("rst_hi_rx_ready", 32'(rx_ready), 0);
        check("rst_hi_cpu_start", 32'(cpu_start), 1);
        check("rst_hi_wr_en", 32'(inst_wr_en), 0);
        @(negedge CLK);
        rx_valid = 1'b0;
        reset    = 1'b0;
        @(negedge CLK);
        check("rst_hi_no_write", 32'(inst_wr_en), 0);
        check("rst_hi_idle_busy", 32'(busy), 0);
        check("rst_hi_idle_rx_ready", 32'(rx_ready), 0);
        @(negedge CLK);
        check("final_writes_left", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
